// File: rtl/monolith_axis_ip_slave_sif.sv
// AXI4-Stream slave deserializer: packs stream words into fixed-size chunks and
// buffers a few chunks, presenting the head chunk in parallel to the hash core.
module monolith_axis_ip_slave_sif #(
    parameter int FIFO_CHUNK_SIZE      = 16,
    parameter int FIFO_CHUNK_COUNT     = 2,
    parameter int C_S_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                S_AXIS_ACLK,
    input  logic                                S_AXIS_ARESET,
    input  logic                                S_AXIS_TVALID,
    output logic                                S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
    input  logic                                S_AXIS_TLAST,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]     chunk_out [FIFO_CHUNK_SIZE],
    output logic [$clog2(FIFO_CHUNK_SIZE):0]    chunk_len,
    output logic                                chunk_last,
    output logic                                chunk_valid,
    input  logic                                chunk_read_strobe
);

    localparam int WW = $clog2(FIFO_CHUNK_SIZE);
    localparam int PW = $clog2(FIFO_CHUNK_COUNT);
    localparam int LW = WW + 1;
    localparam int NW = PW + 1;

    localparam logic [WW-1:0] LAST_WORD   = WW'(FIFO_CHUNK_SIZE - 1);
    localparam logic [NW-1:0] COUNT_FULL1 = NW'(FIFO_CHUNK_COUNT - 1);

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_FULL   = 1'b1
    } state_t;

    state_t state_reg, state_next;

    // Whole head chunk is read in parallel, so storage maps to distributed RAM/registers.
    logic [C_S_AXIS_TDATA_WIDTH-1:0] mem [FIFO_CHUNK_COUNT][FIFO_CHUNK_SIZE];

    logic [PW-1:0]               wr_chunk_reg, wr_chunk_next;
    logic [PW-1:0]               rd_chunk_reg, rd_chunk_next;
    logic [WW-1:0]               wr_word_reg, wr_word_next;
    logic [NW-1:0]               count_reg, count_next;
    logic [LW-1:0]               len_reg [FIFO_CHUNK_COUNT];
    logic [FIFO_CHUNK_COUNT-1:0] last_reg;
    logic [LW-1:0]               len_next;

    logic accept;
    logic commit;
    logic pop;
    logic tready_fsm;
    logic unused_tstrb;

    assign unused_tstrb = ^S_AXIS_TSTRB;

    always_comb begin
        accept        = S_AXIS_TVALID & S_AXIS_TREADY;
        commit        = accept & ((wr_word_reg == LAST_WORD) | S_AXIS_TLAST);
        pop           = chunk_read_strobe & chunk_valid;
        len_next      = {1'b0, wr_word_reg} + LW'(1);
        wr_chunk_next = wr_chunk_reg;
        wr_word_next  = wr_word_reg;
        rd_chunk_next = rd_chunk_reg;
        count_next    = count_reg;

        if (commit) begin
            wr_chunk_next = wr_chunk_reg + PW'(1);
            wr_word_next  = '0;
        end else if (accept) begin
            wr_word_next  = wr_word_reg + WW'(1);
        end

        if (pop) begin
            rd_chunk_next = rd_chunk_reg + PW'(1);
        end

        case ({commit, pop})
            2'b10:   count_next = count_reg + NW'(1);
            2'b01:   count_next = count_reg - NW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        tready_fsm = 1'b0;
        case (state_reg)
            ST_ACCEPT: begin
                tready_fsm = 1'b1;
                if (commit && !pop && (count_reg == COUNT_FULL1)) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                tready_fsm = 1'b0;
                if (pop) begin
                    state_next = ST_ACCEPT;
                end
            end
            default: state_next = ST_ACCEPT;
        endcase
    end

    // Reset only masks TREADY; no data-path input reaches it combinationally.
    assign S_AXIS_TREADY = tready_fsm & ~S_AXIS_ARESET;

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            state_reg    <= ST_ACCEPT;
            wr_chunk_reg <= '0;
            wr_word_reg  <= '0;
            rd_chunk_reg <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            wr_chunk_reg <= wr_chunk_next;
            wr_word_reg  <= wr_word_next;
            rd_chunk_reg <= rd_chunk_next;
            count_reg    <= count_next;
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            for (int i = 0; i < FIFO_CHUNK_COUNT; i++) begin
                len_reg[i] <= '0;
            end
            last_reg <= '0;
        end else if (commit) begin
            len_reg[wr_chunk_reg]  <= len_next;
            last_reg[wr_chunk_reg] <= S_AXIS_TLAST;
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (accept) begin
            mem[wr_chunk_reg][wr_word_reg] <= S_AXIS_TDATA;
        end
    end

    assign chunk_valid = (count_reg != '0);
    assign chunk_len   = len_reg[rd_chunk_reg];
    assign chunk_last  = last_reg[rd_chunk_reg];

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_CHUNK_SIZE; gi++) begin : g_out
            localparam logic [WW-1:0] WORD_IDX = WW'(gi);
            localparam logic [LW-1:0] WORD_NUM = LW'(gi);
            // Words beyond the chunk length read as zero regardless of stale memory.
            assign chunk_out[gi] = (WORD_NUM < chunk_len) ? mem[rd_chunk_reg][WORD_IDX] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_monolith_axis_ip_slave_sif.sv
// Directed bench for monolith_axis_ip_slave_sif: chunk packing, spanning packets,
// backpressure, concurrent commit/pop, zero padding and mid-packet reset.
module tb_monolith_axis_ip_slave_sif;

    logic        clk = 1'b0;
    logic        areset;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic [31:0] chunk_out [16];
    logic [4:0]  chunk_len;
    logic        chunk_last;
    logic        chunk_valid;
    logic        strobe;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    monolith_axis_ip_slave_sif #(
        .FIFO_CHUNK_SIZE      (16),
        .FIFO_CHUNK_COUNT     (2),
        .C_S_AXIS_TDATA_WIDTH (32)
    ) dut (
        .S_AXIS_ACLK       (clk),
        .S_AXIS_ARESET     (areset),
        .S_AXIS_TVALID     (tvalid),
        .S_AXIS_TREADY     (tready),
        .S_AXIS_TDATA      (tdata),
        .S_AXIS_TSTRB      (tstrb),
        .S_AXIS_TLAST      (tlast),
        .chunk_out         (chunk_out),
        .chunk_len         (chunk_len),
        .chunk_last        (chunk_last),
        .chunk_valid       (chunk_valid),
        .chunk_read_strobe (strobe)
    );

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic l);
        int n = 0;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        @(negedge clk);
        while (!tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!tready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout data=%h tready=%b required=1", d, tready);
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        $display("tx word=%h last=%0d", d, l);
    endtask

    task automatic pop_chunk();
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        $display("pop chunk");
    endtask

    task automatic test_reset();
        logic [31:0] acc;
        repeat (2) @(posedge clk);
        @(negedge clk);
        acc = '0;
        for (int i = 0; i < 16; i++) acc |= chunk_out[i];
        checks++; if (tready !== 1'b0) begin failures++; $display("FAIL rst_tready got=%b exp=0", tready); end
        checks++; if (chunk_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", chunk_valid); end
        checks++; if (chunk_len !== 5'd0) begin failures++; $display("FAIL rst_len got=%0d exp=0", chunk_len); end
        checks++; if (chunk_last !== 1'b0) begin failures++; $display("FAIL rst_last got=%b exp=0", chunk_last); end
        checks++; if (acc !== 32'h0) begin failures++; $display("FAIL rst_out got=%h exp=0", acc); end
        @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        checks++; if (tready !== 1'b1) begin failures++; $display("FAIL rst_release_tready got=%b exp=1", tready); end
        @(posedge clk);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_single_chunk();
        for (int i = 0; i < 15; i++) send_word(32'h100 + i, 1'b0);
        checks++; if (chunk_valid !== 1'b0) begin failures++; $display("FAIL single_partial_valid got=%b exp=0", chunk_valid); end
        send_word(32'h10F, 1'b1);
        checks++; if (chunk_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", chunk_valid); end
        checks++; if (chunk_len !== 5'd16) begin failures++; $display("FAIL single_len got=%0d exp=16", chunk_len); end
        checks++; if (chunk_last !== 1'b1) begin failures++; $display("FAIL single_last got=%b exp=1", chunk_last); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (chunk_out[i] !== 32'h100 + i) begin
                failures++;
                $display("FAIL single_out[%0d] got=%h exp=%h", i, chunk_out[i], 32'h100 + i);
            end
        end
        pop_chunk();
        checks++; if (chunk_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid got=%b exp=0", chunk_valid); end
    endtask

    task automatic test_multi_chunk();
        for (int i = 0; i < 20; i++) send_word(32'h200 + i, (i == 19));
        checks++; if (chunk_len !== 5'd16) begin failures++; $display("FAIL multi_len0 got=%0d exp=16", chunk_len); end
        checks++; if (chunk_last !== 1'b0) begin failures++; $display("FAIL multi_last0 got=%b exp=0", chunk_last); end
        checks++; if (chunk_out[15] !== 32'h20F) begin failures++; $display("FAIL multi_out0_15 got=%h exp=20f", chunk_out[15]); end
        pop_chunk();
        checks++; if (chunk_valid !== 1'b1) begin failures++; $display("FAIL multi_valid1 got=%b exp=1", chunk_valid); end
        checks++; if (chunk_len !== 5'd4) begin failures++; $display("FAIL multi_len1 got=%0d exp=4", chunk_len); end
        checks++; if (chunk_last !== 1'b1) begin failures++; $display("FAIL multi_last1 got=%b exp=1", chunk_last); end
        for (int i = 0; i < 16; i++) begin
            logic [31:0] exp_w;
            exp_w = (i < 4) ? 32'h210 + i : 32'h0;
            checks++;
            if (chunk_out[i] !== exp_w) begin
                failures++;
                $display("FAIL multi_out1[%0d] got=%h exp=%h", i, chunk_out[i], exp_w);
            end
        end
        pop_chunk();
        checks++; if (chunk_valid !== 1'b0) begin failures++; $display("FAIL multi_empty got=%b exp=0", chunk_valid); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 32; i++) send_word(32'h300 + i, 1'b0);
        checks++; if (tready !== 1'b0) begin failures++; $display("FAIL bp_full_tready got=%b exp=0", tready); end
        tvalid = 1'b1;
        tdata  = 32'h320;
        tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tready !== 1'b0) begin failures++; $display("FAIL bp_hold_tready got=%b exp=0", tready); end
        checks++; if (chunk_out[0] !== 32'h300) begin failures++; $display("FAIL bp_head0 got=%h exp=300", chunk_out[0]); end
        pop_chunk();
        checks++; if (tready !== 1'b1) begin failures++; $display("FAIL bp_after_pop_tready got=%b exp=1", tready); end
        checks++; if (chunk_out[0] !== 32'h310) begin failures++; $display("FAIL bp_head1 got=%h exp=310", chunk_out[0]); end
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        $display("tx word=00000320 last=0");
        for (int i = 33; i < 40; i++) send_word(32'h300 + i, (i == 39));
        checks++; if (tready !== 1'b0) begin failures++; $display("FAIL bp_refull_tready got=%b exp=0", tready); end
        pop_chunk();
        checks++; if (chunk_len !== 5'd8) begin failures++; $display("FAIL bp_len2 got=%0d exp=8", chunk_len); end
        checks++; if (chunk_last !== 1'b1) begin failures++; $display("FAIL bp_last2 got=%b exp=1", chunk_last); end
        checks++; if (chunk_out[0] !== 32'h320) begin failures++; $display("FAIL bp_word33 got=%h exp=320", chunk_out[0]); end
        checks++; if (chunk_out[7] !== 32'h327) begin failures++; $display("FAIL bp_out7 got=%h exp=327", chunk_out[7]); end
        checks++; if (chunk_out[8] !== 32'h0) begin failures++; $display("FAIL bp_out8 got=%h exp=0", chunk_out[8]); end
        pop_chunk();
        checks++; if (chunk_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", chunk_valid); end
        checks++; if (tready !== 1'b1) begin failures++; $display("FAIL bp_empty_tready got=%b exp=1", tready); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) send_word(32'h400 + i, (i == 2));
        send_word(32'h410, 1'b0);
        send_word(32'h411, 1'b0);
        checks++; if (tready !== 1'b1) begin failures++; $display("FAIL b2b_tready got=%b exp=1", tready); end
        tvalid = 1'b1;
        tdata  = 32'h412;
        tlast  = 1'b1;
        strobe = 1'b1;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        strobe = 1'b0;
        $display("tx word=00000412 last=1 with pop");
        checks++; if (chunk_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", chunk_valid); end
        checks++; if (chunk_len !== 5'd3) begin failures++; $display("FAIL b2b_len got=%0d exp=3", chunk_len); end
        checks++; if (chunk_last !== 1'b1) begin failures++; $display("FAIL b2b_last got=%b exp=1", chunk_last); end
        for (int i = 0; i < 16; i++) begin
            logic [31:0] exp_w;
            exp_w = (i < 3) ? 32'h410 + i : 32'h0;
            checks++;
            if (chunk_out[i] !== exp_w) begin
                failures++;
                $display("FAIL b2b_out[%0d] got=%h exp=%h", i, chunk_out[i], exp_w);
            end
        end
        pop_chunk();
        checks++; if (chunk_valid !== 1'b0) begin failures++; $display("FAIL b2b_count got=%b exp=0", chunk_valid); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] acc;
        for (int i = 0; i < 7; i++) send_word(32'h500 + i, 1'b0);
        areset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc = '0;
        for (int i = 0; i < 16; i++) acc |= chunk_out[i];
        checks++; if (tready !== 1'b0) begin failures++; $display("FAIL mid_tready got=%b exp=0", tready); end
        checks++; if (chunk_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", chunk_valid); end
        checks++; if (chunk_len !== 5'd0) begin failures++; $display("FAIL mid_len got=%0d exp=0", chunk_len); end
        checks++; if (acc !== 32'h0) begin failures++; $display("FAIL mid_out got=%h exp=0", acc); end
        @(posedge clk);
        #1;
        areset = 1'b0;
        for (int i = 0; i < 16; i++) send_word(32'h600 + i, (i == 15));
        checks++; if (chunk_valid !== 1'b1) begin failures++; $display("FAIL mid_new_valid got=%b exp=1", chunk_valid); end
        checks++; if (chunk_len !== 5'd16) begin failures++; $display("FAIL mid_new_len got=%0d exp=16", chunk_len); end
        checks++; if (chunk_last !== 1'b1) begin failures++; $display("FAIL mid_new_last got=%b exp=1", chunk_last); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (chunk_out[i] !== 32'h600 + i) begin
                failures++;
                $display("FAIL mid_new_out[%0d] got=%h exp=%h", i, chunk_out[i], 32'h600 + i);
            end
        end
        pop_chunk();
        checks++; if (chunk_valid !== 1'b0) begin failures++; $display("FAIL mid_empty got=%b exp=0", chunk_valid); end
    endtask

    initial begin
        areset = 1'b1;
        tvalid = 1'b0;
        tdata  = '0;
        tstrb  = 4'hF;
        tlast  = 1'b0;
        strobe = 1'b0;
        test_reset();
        test_single_chunk();
        test_multi_chunk();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
